// File: rtl/mem_responder.sv
// Word-array memory responder for the icache/dcache request handshake.
// Arbitrates one access at a time, holds the owner's wait for LAT cycles, then completes.
module mem_responder #(
   parameter int unsigned LAT     = 2,
   parameter int unsigned DEPTH_W = 10
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload
);

   localparam int unsigned Depth = 1 << DEPTH_W;

   typedef enum logic [1:0] {
      StIdle,
      StDAcc,
      StIAcc
   } state_e;

   state_e               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [DEPTH_W-1:0]   idx_q, idx_d;
   logic                 wr_q, wr_d;
   logic [31:0]          wdata_q, wdata_d;
   logic                 last_d_q, last_d_d;
   logic                 mem_we;
   logic                 d_req, i_req;
   logic [31:0]          mem_q [Depth];
   logic [31:0]          rdata;

   // Address bits outside the word index are deliberately ignored (aliasing).
   logic unused_addr;
   assign unused_addr = ^{iaddr[31:DEPTH_W+2], iaddr[1:0], daddr[31:DEPTH_W+2], daddr[1:0]};

   assign d_req = dREN | dWEN;
   assign i_req = iREN;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      wr_d     = wr_q;
      wdata_d  = wdata_q;
      last_d_d = last_d_q;
      mem_we   = 1'b0;
      case (state_q)
         StIdle: begin
            // On a tie the side that did not complete last wins.
            if (d_req && (!i_req || !last_d_q)) begin
               state_d = StDAcc;
               cnt_d   = 4'(LAT);
               idx_d   = daddr[DEPTH_W+1:2];
               wr_d    = dWEN;
               wdata_d = dstore;
            end else if (i_req) begin
               state_d = StIAcc;
               cnt_d   = 4'(LAT);
               idx_d   = iaddr[DEPTH_W+1:2];
               wr_d    = 1'b0;
               wdata_d = dstore;
            end
         end
         StDAcc: begin
            // Wait is already low at cnt==0, so that cycle always completes.
            if (cnt_q == 4'd0) begin
               mem_we   = wr_q;
               last_d_d = 1'b1;
               state_d  = StIdle;
            end else if (!d_req) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StIAcc: begin
            if (cnt_q == 4'd0) begin
               last_d_d = 1'b0;
               state_d  = StIdle;
            end else if (!i_req) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= StIdle;
         cnt_q    <= 4'd0;
         idx_q    <= '0;
         wr_q     <= 1'b0;
         wdata_q  <= 32'd0;
         last_d_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         wr_q     <= wr_d;
         wdata_q  <= wdata_d;
         last_d_q <= last_d_d;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= 32'd0;
         end
      end else if (mem_we) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   assign rdata = mem_q[idx_q];

   always_comb begin
      dwait = !((state_q == StDAcc) && (cnt_q == 4'd0));
      iwait = !((state_q == StIAcc) && (cnt_q == 4'd0));
      dload = (state_q == StDAcc) ? rdata : 32'd0;
      iload = (state_q == StIAcc) ? rdata : 32'd0;
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with LAT=2, DEPTH_W=10.
module tb_mem_responder;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        iREN = 1'b0;
   logic [31:0] iaddr = 32'd0;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN = 1'b0;
   logic        dWEN = 1'b0;
   logic [31:0] daddr = 32'd0;
   logic [31:0] dstore = 32'd0;
   logic        dwait;
   logic [31:0] dload;

   int checks = 0;
   int failures = 0;

   mem_responder #(.LAT(2), .DEPTH_W(10)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .iREN   (iREN),
      .iaddr  (iaddr),
      .iwait  (iwait),
      .iload  (iload),
      .dREN   (dREN),
      .dWEN   (dWEN),
      .daddr  (daddr),
      .dstore (dstore),
      .dwait  (dwait),
      .dload  (dload)
   );

   always #5 CLK = ~CLK;

   task automatic apply_reset();
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   // Stimulus only: cycle 0 is the IDLE cycle in which the request is first seen.
   task automatic d_access(input logic wen, input logic [31:0] addr, input logic [31:0] data,
                           output int cyc, output logic [31:0] ld);
      @(negedge CLK);
      dREN = !wen;
      dWEN = wen;
      daddr = addr;
      dstore = data;
      cyc = -1;
      ld = 32'hx;
      for (int c = 0; c < 20; c++) begin
         if (c > 0) @(negedge CLK);
         if (dwait === 1'b0) begin
            cyc = c;
            ld = dload;
            break;
         end
      end
      dREN = 1'b0;
      dWEN = 1'b0;
   endtask

   task automatic i_access(input logic [31:0] addr, output int cyc, output logic [31:0] ld);
      @(negedge CLK);
      iREN = 1'b1;
      iaddr = addr;
      cyc = -1;
      ld = 32'hx;
      for (int c = 0; c < 20; c++) begin
         if (c > 0) @(negedge CLK);
         if (iwait === 1'b0) begin
            cyc = c;
            ld = iload;
            break;
         end
      end
      iREN = 1'b0;
   endtask

   task automatic test_reset();
      int cyc;
      logic [31:0] ld;
      apply_reset();
      checks++;
      if (iwait !== 1'b1 || dwait !== 1'b1 || iload !== 32'd0 || dload !== 32'd0) begin
         failures++;
         $display("FAIL reset_outputs: iwait=%b dwait=%b iload=%h dload=%h, required 1 1 0 0",
                  iwait, dwait, iload, dload);
      end
      d_access(1'b0, 32'h40, 32'd0, cyc, ld);
      checks++;
      if (cyc != 3 || ld !== 32'd0) begin
         failures++;
         $display("FAIL reset_first_read: cycle=%0d load=%h, required cycle=3 load=0", cyc, ld);
      end
   endtask

   task automatic test_write_read();
      int cyc;
      logic [31:0] ld;
      d_access(1'b1, 32'h100, 32'hDEADBEEF, cyc, ld);
      checks++;
      if (cyc != 3 || ld !== 32'd0) begin
         failures++;
         $display("FAIL write_completion: cycle=%0d load=%h, required cycle=3 load=0", cyc, ld);
      end
      d_access(1'b0, 32'h100, 32'd0, cyc, ld);
      checks++;
      if (cyc != 3 || ld !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL d_read_after_write: cycle=%0d load=%h, required cycle=3 load=deadbeef",
                  cyc, ld);
      end
      i_access(32'h100, cyc, ld);
      checks++;
      if (cyc != 3 || ld !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL i_read_after_write: cycle=%0d load=%h, required cycle=3 load=deadbeef",
                  cyc, ld);
      end
   endtask

   task automatic test_aliasing();
      int cyc;
      logic [31:0] ld;
      d_access(1'b1, 32'h4, 32'h12345678, cyc, ld);
      checks++;
      if (cyc != 3) begin
         failures++;
         $display("FAIL alias_write: cycle=%0d, required 3", cyc);
      end
      d_access(1'b0, 32'h1004, 32'd0, cyc, ld);
      checks++;
      if (ld !== 32'h12345678) begin
         failures++;
         $display("FAIL alias_high_bits: load=%h, required 12345678", ld);
      end
      d_access(1'b0, 32'h7, 32'd0, cyc, ld);
      checks++;
      if (ld !== 32'h12345678) begin
         failures++;
         $display("FAIL alias_low_bits: load=%h, required 12345678", ld);
      end
      i_access(32'h1004, cyc, ld);
      checks++;
      if (ld !== 32'h12345678) begin
         failures++;
         $display("FAIL alias_icache: load=%h, required 12345678", ld);
      end
   endtask

   task automatic test_back_to_back();
      int first_c = -1;
      int second_c = -1;
      logic [31:0] first_ld = 32'hx;
      logic [31:0] second_ld = 32'hx;
      @(negedge CLK);
      dREN = 1'b1;
      daddr = 32'h100;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge CLK);
         if (dwait === 1'b0) begin
            if (first_c < 0) begin
               first_c = c;
               first_ld = dload;
               daddr = 32'h4;
            end else if (second_c < 0) begin
               second_c = c;
               second_ld = dload;
               dREN = 1'b0;
            end
         end
      end
      dREN = 1'b0;
      checks++;
      if (first_c != 3 || first_ld !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL b2b_first: cycle=%0d load=%h, required cycle=3 load=deadbeef",
                  first_c, first_ld);
      end
      checks++;
      if (second_c != 7 || second_ld !== 32'h12345678) begin
         failures++;
         $display("FAIL b2b_second: cycle=%0d load=%h, required cycle=7 load=12345678",
                  second_c, second_ld);
      end
   endtask

   task automatic test_abort();
      int cyc;
      int lows = 0;
      logic [31:0] ld;
      @(negedge CLK);
      dWEN = 1'b1;
      daddr = 32'h200;
      dstore = 32'hAAAA5555;
      for (int c = 0; c < 7; c++) begin
         if (c > 0) @(negedge CLK);
         if (c == 2) dWEN = 1'b0;
         if (dwait !== 1'b1) lows++;
      end
      checks++;
      if (lows != 0) begin
         failures++;
         $display("FAIL abort_dwait: low_cycles=%0d, required 0", lows);
      end
      d_access(1'b0, 32'h200, 32'd0, cyc, ld);
      checks++;
      if (cyc != 3 || ld !== 32'd0) begin
         failures++;
         $display("FAIL abort_no_write: cycle=%0d load=%h, required cycle=3 load=0", cyc, ld);
      end
   endtask

   task automatic test_reset_mid_write();
      int cyc;
      logic [31:0] ld;
      @(negedge CLK);
      dWEN = 1'b1;
      daddr = 32'h300;
      dstore = 32'h1;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      #1;
      checks++;
      if (iwait !== 1'b1 || dwait !== 1'b1 || iload !== 32'd0 || dload !== 32'd0) begin
         failures++;
         $display("FAIL mid_reset_outputs: iwait=%b dwait=%b iload=%h dload=%h, required 1 1 0 0",
                  iwait, dwait, iload, dload);
      end
      dWEN = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      d_access(1'b0, 32'h300, 32'd0, cyc, ld);
      checks++;
      if (cyc != 3 || ld !== 32'd0) begin
         failures++;
         $display("FAIL mid_reset_no_write: cycle=%0d load=%h, required cycle=3 load=0", cyc, ld);
      end
   endtask

   task automatic test_contention();
      int d1 = -1;
      int d2 = -1;
      int i1 = -1;
      int both = 0;
      apply_reset();
      @(negedge CLK);
      iREN = 1'b1;
      iaddr = 32'h0;
      dREN = 1'b1;
      daddr = 32'h8;
      for (int c = 0; c < 13; c++) begin
         if (c > 0) @(negedge CLK);
         if (dwait === 1'b0 && iwait === 1'b0) both++;
         if (dwait === 1'b0) begin
            if (d1 < 0) d1 = c;
            else if (d2 < 0) d2 = c;
         end
         if (iwait === 1'b0 && i1 < 0) i1 = c;
      end
      iREN = 1'b0;
      dREN = 1'b0;
      checks++;
      if (d1 != 3) begin
         failures++;
         $display("FAIL contention_d_first: cycle=%0d, required 3", d1);
      end
      checks++;
      if (i1 != 7) begin
         failures++;
         $display("FAIL contention_i: cycle=%0d, required 7", i1);
      end
      checks++;
      if (d2 != 11) begin
         failures++;
         $display("FAIL contention_d_second: cycle=%0d, required 11", d2);
      end
      checks++;
      if (both != 0) begin
         failures++;
         $display("FAIL contention_both_low: cycles=%0d, required 0", both);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_aliasing();
      test_back_to_back();
      test_abort();
      test_reset_mid_write();
      test_contention();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
